// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs MIPS instructions from valid/ready beats into consecutive imem words
module instr_encoder_loader #(
    parameter int DEPTH = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [ADDR_W:0] full = (ADDR_W+1)'(DEPTH);
    state_t state;
    logic acc;
    logic legal;
    logic [5:0] op;
    logic [31:0] enc;
    assign in_ready = state == LOAD && count < full && !start;
    assign acc = in_valid && in_ready;
    assign busy = state == LOAD;
    assign done = state == DONE;
    always_comb begin
        legal = in_kind <= 4'd8;
        op = in_kind == 4'd1 ? 6'b100011 :
             in_kind == 4'd2 ? 6'b101011 :
             in_kind == 4'd3 ? 6'b000100 :
             in_kind == 4'd4 ? 6'b001000 :
             in_kind == 4'd5 ? 6'b001101 :
             in_kind == 4'd7 ? 6'b000101 :
             in_kind == 4'd8 ? 6'b001100 : 6'b000000;
        enc = in_kind == 4'd0 ? {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct} :
              in_kind == 4'd6 ? {6'b000010, in_target} : {op, in_rs, in_rt, in_imm};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            err <= 1'b0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wd <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state <= LOAD;
                count <= '0;
                err <= 1'b0;
            end else if (state == LOAD) begin
                if (acc && legal) begin
                    imem_we <= 1'b1;
                    imem_addr <= count[ADDR_W-1:0];
                    imem_wd <= enc;
                    count <= count + 1'b1;
                end
                if (acc && !legal)
                    err <= 1'b1;
                if (finish || (acc && legal && count + 1'b1 == full))
                    state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: vector table, corner sequences and random traffic against a reference model
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic reset, start, finish, in_valid;
    logic [3:0] in_kind;
    logic [4:0] in_rs, in_rt, in_rd;
    logic [5:0] in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic a_ready, a_we, a_busy, a_done, a_err;
    logic [5:0] a_addr;
    logic [6:0] a_count;
    logic [31:0] a_wd;
    logic b_ready, b_we, b_busy, b_done, b_err;
    logic [1:0] b_addr;
    logic [2:0] b_count;
    logic [31:0] b_wd;
    int n_tests = 0;
    int n_fail = 0;
    int m_st[2], m_cnt[2], m_addr[2];
    bit m_err[2], m_we[2];
    logic [31:0] m_wd[2];
    int dep[2] = '{64, 4};

    instr_encoder_loader #(.DEPTH(64), .ADDR_W(6)) dut_a (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(a_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .imem_we(a_we),
        .imem_addr(a_addr), .imem_wd(a_wd), .count(a_count), .busy(a_busy), .done(a_done), .err(a_err)
    );
    instr_encoder_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(b_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .imem_we(b_we),
        .imem_addr(b_addr), .imem_wd(b_wd), .count(b_count), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kind;
        logic [4:0] rs, rt, rd;
        logic [5:0] funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] wd;
    } vec_t;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(int kind, int rs, int rt, int rd, int funct, int imm, int target);
        longint w;
        int ops[9];
        ops = '{0, 35, 43, 4, 8, 13, 2, 5, 12};
        if (kind == 0) w = longint'(rs) * 2**21 + rt * 2**16 + rd * 2**11 + funct;
        else if (kind == 6) w = longint'(2) * 2**26 + target;
        else w = longint'(ops[kind]) * 2**26 + longint'(rs) * 2**21 + rt * 2**16 + imm;
        return 32'(w);
    endfunction

    task automatic step();
        bit rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy = m_st[k] == 1 && m_cnt[k] < dep[k] && !start;
            chk(k == 0 ? "a_ready" : "b_ready", k == 0 ? 32'(a_ready) : 32'(b_ready), 32'(rdy));
            m_we[k] = 0;
            if (reset) begin
                m_st[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
            end else if (start) begin
                m_st[k] = 1; m_cnt[k] = 0; m_err[k] = 0;
            end else if (m_st[k] == 1) begin
                if (in_valid && rdy && in_kind <= 8) begin
                    m_we[k] = 1;
                    m_addr[k] = m_cnt[k];
                    m_wd[k] = ref_enc(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
                    m_cnt[k]++;
                end else if (in_valid && rdy) m_err[k] = 1;
                if (finish || m_cnt[k] == dep[k]) m_st[k] = 2;
            end
        end
        @(posedge clk);
        #1;
        chk("a_we", 32'(a_we), 32'(m_we[0]));
        chk("a_addr", 32'(a_addr), 32'(m_addr[0]));
        chk("a_wd", a_wd, m_wd[0]);
        chk("a_count", 32'(a_count), 32'(m_cnt[0]));
        chk("a_busy", 32'(a_busy), 32'(m_st[0] == 1));
        chk("a_done", 32'(a_done), 32'(m_st[0] == 2));
        chk("a_err", 32'(a_err), 32'(m_err[0]));
        chk("b_we", 32'(b_we), 32'(m_we[1]));
        chk("b_addr", 32'(b_addr), 32'(m_addr[1]));
        chk("b_wd", b_wd, m_wd[1]);
        chk("b_count", 32'(b_count), 32'(m_cnt[1]));
        chk("b_busy", 32'(b_busy), 32'(m_st[1] == 1));
        chk("b_done", 32'(b_done), 32'(m_st[1] == 2));
        chk("b_err", 32'(b_err), 32'(m_err[1]));
    endtask

    task automatic beat(vec_t v);
        in_valid = 1; in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_funct = v.funct; in_imm = v.imm; in_target = v.target;
    endtask

    task automatic quiet();
        in_valid = 0; start = 0; finish = 0;
    endtask

    task automatic pulse_start();
        quiet();
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int nw;
        tbl[0] = '{4'd4, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h20080005};
        tbl[1] = '{4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0, 32'h01095020};
        tbl[2] = '{4'd1, 5'd8, 5'd9, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h8D090004};
        tbl[3] = '{4'd7, 5'd8, 5'd9, 5'd0, 6'h00, 16'hFFFE, 26'h0, 32'h1509FFFE};
        tbl[4] = '{4'd6, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 32'h08000010};
        tbl[5] = '{4'd5, 5'd1, 5'd2, 5'd7, 6'h3F, 16'h1234, 26'h0, 32'h34221234};
        tbl[6] = '{4'd8, 5'd3, 5'd4, 5'd0, 6'h00, 16'h00FF, 26'h3FFFFFF, 32'h306400FF};
        tbl[7] = '{4'd3, 5'd5, 5'd6, 5'd0, 6'h00, 16'h0003, 26'h0, 32'h10A60003};
        tbl[8] = '{4'd2, 5'd29, 5'd31, 5'd0, 6'h00, 16'h0008, 26'h0, 32'hAFBF0008};
        reset = 1; quiet();
        in_kind = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_funct = 0; in_imm = 0; in_target = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
        end
        chk("rst_ready", 32'(a_ready), 0);
        chk("rst_we", 32'(a_we), 0);
        chk("rst_wd", a_wd, 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_busy_done_err", {a_busy, a_done, a_err}, 0);
        reset = 0;
        step();

        pulse_start();
        for (int i = 0; i < 9; i++) begin
            beat(tbl[i]);
            step();
            chk("tbl_we", 32'(a_we), 1);
            chk("tbl_addr", 32'(a_addr), i);
            chk("tbl_wd", a_wd, tbl[i].wd);
            chk("tbl_count", 32'(a_count), i + 1);
        end
        quiet();
        step();
        chk("tbl_we_pulse", 32'(a_we), 0);
        chk("tbl_wd_hold", a_wd, 32'hAFBF0008);

        pulse_start();
        beat(tbl[0]);
        step();
        v = tbl[2];
        v.kind = 4'd12;
        beat(v);
        #1;
        chk("illegal_ready", 32'(a_ready), 1);
        step();
        chk("illegal_we", 32'(a_we), 0);
        chk("illegal_err", 32'(a_err), 1);
        chk("illegal_count", 32'(a_count), 1);
        beat(tbl[2]);
        step();
        chk("after_illegal_addr", 32'(a_addr), 1);
        chk("after_illegal_wd", a_wd, 32'h8D090004);

        pulse_start();
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            beat(tbl[i]);
            step();
            nw += int'(b_we);
        end
        quiet();
        #1;
        chk("full_writes", nw, 4);
        chk("full_ready", 32'(b_ready), 0);
        chk("full_done", 32'(b_done), 1);
        chk("full_count", 32'(b_count), 4);
        chk("full_last_addr", 32'(b_addr), 3);

        pulse_start();
        beat(tbl[8]);
        finish = 1;
        step();
        chk("finish_we", 32'(a_we), 1);
        chk("finish_wd", a_wd, 32'hAFBF0008);
        quiet();
        step();
        chk("finish_done", 32'(a_done), 1);
        chk("finish_busy", 32'(a_busy), 0);
        chk("finish_hold_count", 32'(a_count), 1);
        pulse_start();
        chk("restart_count", 32'(a_count), 0);
        chk("restart_err", 32'(a_err), 0);
        beat(tbl[5]);
        step();
        chk("restart_addr", 32'(a_addr), 0);

        pulse_start();
        beat(tbl[1]);
        step();
        quiet();
        reset = 1;
        step();
        reset = 0;
        chk("midrst_we", 32'(a_we), 0);
        chk("midrst_count", 32'(a_count), 0);
        chk("midrst_wd", a_wd, 0);
        chk("midrst_state", {a_busy, a_done, a_err}, 0);
        step();

        for (int i = 0; i < 800; i++) begin
            reset = $urandom_range(0, 99) == 0;
            start = $urandom_range(0, 19) == 0;
            finish = $urandom_range(0, 24) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_kind = 4'($urandom_range(0, 15));
            in_rs = 5'($urandom);
            in_rt = 5'($urandom);
            in_rd = 5'($urandom);
            in_funct = 6'($urandom);
            in_imm = 16'($urandom);
            in_target = 26'($urandom);
            step();
        end
        reset = 0;
        quiet();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and instruction-memory loader for the single-cycle MIPS core; the encoding counterpart of the main control decoder. It accepts one instruction per valid/ready beat as an instruction kind plus operand fields. Each beat is packed into a 32-bit MIPS word using the opcodes the core's decoder recognises, and written to consecutive instruction-memory words. It is used by bring-up and test infrastructure to fill instruction memory before the core is released from reset.

## Interface
Parameters:
- DEPTH, 64, number of instruction-memory words that can be loaded
- ADDR_W, 6, word-address width; DEPTH <= 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: begin (or restart) a load session at word 0
- finish  in  1  single-cycle pulse: end the session
- in_valid  in  1  instruction beat present
- in_ready  out  1  loader can accept a beat this cycle
- in_kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 ORI, 6 J, 7 BNE, 8 ANDI, 9-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type function field
- in_imm  in  16  immediate or branch offset
- in_target  in  26  jump target field
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of the write
- imem_wd  out  32  encoded instruction word
- count  out  ADDR_W+1  words written this session
- busy  out  1  session in progress (LOAD state)
- done  out  1  session ended (DONE state)
- err  out  1  sticky: an illegal kind was received this session

## Operation
- Three-state FSM: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DONE on finish, or when count reaches DEPTH.
  - From any state, start re-enters LOAD: write pointer = 0, count = 0, err = 0.
- in_ready = 1 only when state is LOAD, count < DEPTH, and start = 0.
- A beat is accepted when in_valid & in_ready.
- Encoding, with op in bits 31:26:
  - RTYPE: {000000, rs, rt, rd, 00000, funct}
  - LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ORI 001101, ANDI 001100: {op, rs, rt, imm}
  - J: {000010, target}
  - Fields not used by a kind are ignored.
- Illegal kind (9-15): the beat is consumed (handshake completes), nothing is written, count is unchanged, and err is set.
- Write pointer and count increment by 1 per legal beat. The pointer never wraps; acceptance stops at DEPTH.
- finish in the same cycle as an accepted beat: the beat is written, then the FSM enters DONE.
- finish in IDLE or DONE is ignored.
- In DONE, count, err, and the final memory contents hold until the next start or reset.

## Timing
- Reset: state IDLE. in_ready, imem_we, imem_addr, imem_wd, count, busy, done, and err are all 0.
- Latency 1: a legal beat accepted in cycle N produces imem_we = 1 in cycle N+1, with imem_addr = the pre-increment pointer and imem_wd = the encoded word.
- count updates in cycle N+1, together with imem_we.
- imem_we is a single-cycle pulse per legal beat.
- imem_addr and imem_wd hold their last values when imem_we = 0.
- Throughput: one beat per cycle sustained.
- Full: the DEPTH-th legal beat is accepted in cycle N. In cycle N+1 its write occurs, count = DEPTH, and state = DONE. in_ready is 0 from cycle N+1.
- err asserts in the cycle after the illegal beat is accepted.
- busy and done reflect the registered state.
- Reset mid-session: at the next edge, everything returns to reset values and no further write is issued. Already-written memory words are not cleared.

## Test plan
- Reset, then start, then ADDI rs=0 rt=8 imm=5 -> one cycle later imem_we=1, imem_addr=0, imem_wd=0x20080005, count=1.
- Back-to-back beats on consecutive cycles: RTYPE rs=8 rt=9 rd=10 funct=0x20; LW rs=8 rt=9 imm=4; BNE rs=8 rt=9 imm=0xFFFE; J target=0x10 -> writes 0x01095020, 0x8D090004, 0x1509FFFE, 0x08000010 at addresses 0-3 on consecutive cycles, then count=4.
- in_kind=12 mid-stream -> in_ready stays 1, no write for that beat, err=1 from the next cycle, and the following legal beat is written at the next sequential address.
- DEPTH=4: five valid beats offered -> exactly four writes, then in_ready=0, done=1, count=4; the fifth beat is never accepted.
- finish in the same cycle as an accepted SW rs=29 rt=31 imm=8 -> write 0xAFBF0008 occurs, then done=1, busy=0; a later start gives count=0, err=0, and the next write goes to address 0.
- reset asserted in the cycle after a beat is accepted -> no write that cycle; all outputs 0 on the following cycle.
